sequence_match_logger: RTL and testbench
========================================

// Module: sequence_match_logger
// PURPOSE
//  Sits directly downstream of the 3-bit symbol sequence detector and consumes its
//  one-cycle sequence_found pulse. Timestamps each match against a free-running
//  cycle counter and buffers the timestamps in a small FIFO, read out over valid/ready.
//  Also keeps a saturating total-match count and a sticky overflow flag for status readout.
// PARAMETERS
//  TS_W   16  timestamp / gap width in bits
//  DEPTH  4   FIFO entries; power of two, >= 2
//  CNT_W  8   match counter width in bits
// PORTS
//  clk             in   1             system clock; all state on rising edge
//  reset_n         in   1             asynchronous, active-low reset
//  clear           in   1             synchronous clear of all state (see BEHAVIOUR)
//  sequence_found  in   1             match pulse from detector; one push per high cycle
//  evt_ready       in   1             consumer accepts head entry
//  evt_valid       out  1             FIFO non-empty; evt_ts holds head entry
//  evt_ts          out  TS_W          head-entry timestamp (or gap, see CONFIGURATION)
//  match_count     out  CNT_W         total matches seen, saturating
//  overflow        out  1             sticky: a match was dropped because FIFO was full
//  fifo_level      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Clock/reset: one clock domain, clk. reset_n is asynchronous and active-low.
//  - Reset: ts counter, FIFO pointers, fifo_level, match_count and overflow all 0.
//    evt_valid=0, evt_ts=0. Asserting reset mid-operation discards all FIFO contents.
//  - Timestamp counter: ts is 0 in the first cycle after reset release. It increments by 1
//    every cycle and wraps from 2^TS_W-1 to 0.
//  - Push: in a cycle with sequence_found=1, the pushed entry is the ts value of that cycle
//    (pre-increment). It is written at the rising edge that ends that cycle.
//  - Pop: a pop happens when evt_valid && evt_ready at a rising edge. The head advances at
//    that edge.
//  - Latency: a push into an empty FIFO gives evt_valid=1 in the next cycle. There is no
//    same-cycle bypass.
//  - evt_valid = (fifo_level != 0). evt_ts is the registered head entry; it is stable while
//    evt_valid && !evt_ready.
//  - evt_ts is don't-care while evt_valid=0. The bench must not check it then.
//  - Full (level == DEPTH) with push and no pop: the entry is dropped, overflow is set
//    (sticky), and the FIFO is unchanged.
//  - Full with simultaneous push and pop: both are accepted. Level stays DEPTH; no drop and
//    no overflow.
//  - Empty with evt_ready=1: no pop. evt_ready is ignored when evt_valid=0.
//  - Pointers wrap modulo DEPTH. fifo_level changes by +1, -1 or 0 per cycle.
//  - match_count increments on every sequence_found=1 cycle, including dropped ones.
//    It saturates at 2^CNT_W-1.
//  - clear=1 (synchronous): at the next edge, sets fifo_level=0, match_count=0, overflow=0
//    and ts=0 (plus gap=0 in gap mode).
//  - clear has priority over a push or pop in the same cycle; that match is neither stored
//    nor counted.
//  - Back-to-back sequence_found pulses each push a separate entry.
// CONFIGURATION
//  SEQ_LOGGER_GAP_EN defined:
//  - A gap counter replaces the absolute timestamp in FIFO entries. The gap is the number
//    of cycles since the previous match.
//  - The gap register resets/clears to 0 and increments every cycle, saturating at
//    2^TS_W-1 (no wrap).
//  - On a match, the current gap value is pushed and the gap register returns to 0 at that
//    edge. This happens even if the push is dropped.
//  - Back-to-back matches therefore push 0. The first match after reset or clear pushes the
//    number of cycles since release.
//  - The free-running ts counter is not instantiated.
//  SEQ_LOGGER_GAP_EN undefined: absolute wrapping timestamp as described above.
// TESTING
//  1 Reset release; pulse sequence_found at ts=5 -> next cycle: evt_valid=1, evt_ts=5,
//    fifo_level=1, match_count=1.
//  2 evt_ready=0; pulse at ts=3,4,9,12,20 (DEPTH=4) -> level=4; 5th pulse dropped,
//    overflow=1, match_count=5. Drain yields 3,4,9,12.
//  3 FIFO full, evt_ready=1 and pulse at ts=30 in the same cycle -> head popped, 30 stored,
//    level stays 4, overflow stays 0.
//  4 Pulse every cycle for 300 cycles with CNT_W=8, evt_ready=1 -> match_count=255
//    (saturated), no overflow.
//  5 clear coincident with a pulse, FIFO holding 2 entries -> next cycle: level=0,
//    evt_valid=0, count=0, overflow=0, ts=0.
//  6 GAP_EN: pulses at cycles 7, 8 and 20 after reset -> entries 7, 0, 11. Also assert
//    reset_n low mid-drain -> evt_valid=0 immediately.

Source files
------------

// File: rtl/sequence_match_logger.sv
// Timestamps sequence_found pulses into a small valid/ready FIFO and keeps match/overflow status.
// Define SEQ_LOGGER_GAP_EN to store inter-match gaps instead of absolute timestamps.
`timescale 1ns/1ps
module sequence_match_logger #(
   parameter int TS_W  = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     sequence_found,
   input  logic                     evt_ready,
   output logic                     evt_valid,
   output logic [TS_W-1:0]          evt_ts,
   output logic [CNT_W-1:0]         match_count,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [TS_W-1:0]  stamp;
   logic [TS_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_nxt;
   logic             push_req;
   logic             pop;
   logic             full;
   logic             wr_en;

   // clear overrides the handshake: a match or pop in a clearing cycle has no effect
   assign push_req  = sequence_found && !clear;
   assign pop       = evt_valid && evt_ready && !clear;
   assign full      = (fifo_level == LVL_W'(DEPTH));
   assign wr_en     = push_req && (!full || pop);
   assign evt_valid = (fifo_level != '0);
   assign evt_ts    = mem[rd_ptr];

`ifdef SEQ_LOGGER_GAP_EN
   logic [TS_W-1:0] gap;

   // Saturates rather than wraps; restarts on every match, even one that is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         gap <= '0;
      else if (clear || sequence_found)
         gap <= '0;
      else if (gap != '1)
         gap <= gap + TS_W'(1);
   end

   assign stamp = gap;
`else
   logic [TS_W-1:0] ts;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ts <= '0;
      else if (clear)
         ts <= '0;
      else
         ts <= ts + TS_W'(1);
   end

   assign stamp = ts;
`endif

   // NOTE: the storage array is reset too so evt_ts reads 0 out of reset; at this depth it is cheap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_ptr] <= stamp;
      end
   end

   // When full with a pop, wr_ptr equals rd_ptr: the old head leaves as the new tail lands there
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_level <= level_nxt;
      end
   end

   // NOTE: default assignment first so this always_comb cannot infer a latch.
   always_comb begin
      level_nxt = fifo_level;
      if (wr_en && !pop)
         level_nxt = fifo_level + LVL_W'(1);
      else if (!wr_en && pop)
         level_nxt = fifo_level - LVL_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         match_count <= '0;
      else if (clear)
         match_count <= '0;
      else if (sequence_found && match_count != '1)
         match_count <= match_count + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         overflow <= 1'b0;
      else if (clear)
         overflow <= 1'b0;
      else if (push_req && full && !pop)
         overflow <= 1'b1;
   end

endmodule

// File: tb/tb_sequence_match_logger.sv
// Directed table-driven bench for sequence_match_logger plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_sequence_match_logger;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clear;
   logic        sequence_found;
   logic        evt_ready;
   logic        evt_valid;
   logic [15:0] evt_ts;
   logic [7:0]  match_count;
   logic        overflow;
   logic [2:0]  fifo_level;

   int n_checks = 0;
   int n_errors = 0;
   int tb_ts    = 0;
   int last_ts  = 0;

   sequence_match_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear          (clear),
      .sequence_found (sequence_found),
      .evt_ready      (evt_ready),
      .evt_valid      (evt_valid),
      .evt_ts         (evt_ts),
      .match_count    (match_count),
      .overflow       (overflow),
      .fifo_level     (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic sf;
      logic rdy;
      logic clr;
      int   reps;
      logic ev;
      int   ts;
      int   lvl;
      int   cnt;
      logic ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic sf, rdy, clr, input int reps,
                      input logic ev, input int ts, lvl, cnt, input logic ovf);
      vec_t v;
      v.sf = sf; v.rdy = rdy; v.clr = clr; v.reps = reps;
      v.ev = ev; v.ts = ts; v.lvl = lvl; v.cnt = cnt; v.ovf = ovf;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Inputs are held for one clock; outputs are sampled 1 ns after the edge.
   task automatic step(input logic sf, rdy, clr);
      sequence_found = sf;
      evt_ready      = rdy;
      clear          = clr;
      last_ts        = tb_ts;
      @(posedge clk);
      #1;
      tb_ts = clr ? 0 : (tb_ts + 1) % 65536;
   endtask

   task automatic check_state(input string tag, input logic ev, input int ts,
                              input int lvl, input int cnt, input logic ovf);
      check({tag, " evt_valid"}, int'(evt_valid), int'(ev));
      check({tag, " fifo_level"}, int'(fifo_level), lvl);
      check({tag, " match_count"}, int'(match_count), cnt);
      check({tag, " overflow"}, int'(overflow), int'(ovf));
`ifndef SEQ_LOGGER_GAP_EN
      if (ev)
         check({tag, " evt_ts"}, int'(evt_ts), ts);
`endif
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      tb_ts   = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int exp_gap[3];

      reset_n = 1'b0; clear = 1'b0; sequence_found = 1'b0; evt_ready = 1'b0;

      // Reset state, including the head register
      repeat (3) @(posedge clk);
      #1;
      check_state("reset", 1'b0, 0, 0, 0, 1'b0);
      check("reset evt_ts", int'(evt_ts), 0);

      // sf rdy clr reps | valid ts lvl cnt ovf ; the row applies while ts equals the noted value
      add(0, 0, 0, 5,   0,  0, 0, 0, 0);   // ts 0..4 idle
      add(1, 0, 0, 1,   1,  5, 1, 1, 0);   // match at ts=5
      add(0, 1, 0, 1,   0,  0, 0, 1, 0);   // pop
      add(0, 0, 1, 1,   0,  0, 0, 0, 0);   // clear at ts=7
      add(0, 0, 0, 3,   0,  0, 0, 0, 0);   // ts 0..2
      add(1, 0, 0, 1,   1,  3, 1, 1, 0);   // ts 3
      add(1, 0, 0, 1,   1,  3, 2, 2, 0);   // ts 4
      add(0, 0, 0, 4,   1,  3, 2, 2, 0);   // ts 5..8
      add(1, 0, 0, 1,   1,  3, 3, 3, 0);   // ts 9
      add(0, 0, 0, 2,   1,  3, 3, 3, 0);   // ts 10..11
      add(1, 0, 0, 1,   1,  3, 4, 4, 0);   // ts 12, now full
      add(0, 0, 0, 7,   1,  3, 4, 4, 0);   // ts 13..19
      add(1, 0, 0, 1,   1,  3, 4, 5, 1);   // ts 20 dropped
      add(0, 1, 0, 1,   1,  4, 3, 5, 1);   // drain
      add(0, 1, 0, 1,   1,  9, 2, 5, 1);
      add(0, 1, 0, 1,   1, 12, 1, 5, 1);
      add(0, 1, 0, 1,   0,  0, 0, 5, 1);
      add(0, 1, 0, 1,   0,  0, 0, 5, 1);   // empty with ready: no pop
      add(0, 0, 1, 1,   0,  0, 0, 0, 0);   // clear at ts=26 drops overflow
      add(1, 0, 0, 1,   1,  0, 1, 1, 0);   // ts 0..3 fill
      add(1, 0, 0, 1,   1,  0, 2, 2, 0);
      add(1, 0, 0, 1,   1,  0, 3, 3, 0);
      add(1, 0, 0, 1,   1,  0, 4, 4, 0);
      add(0, 0, 0, 26,  1,  0, 4, 4, 0);   // ts 4..29
      add(1, 1, 0, 1,   1,  1, 4, 5, 0);   // full, push+pop at ts=30
      add(0, 1, 0, 1,   1,  2, 3, 5, 0);
      add(0, 1, 0, 1,   1,  3, 2, 5, 0);
      add(0, 1, 0, 1,   1, 30, 1, 5, 0);
      add(0, 1, 0, 1,   0,  0, 0, 5, 0);   // ts 34
      add(1, 0, 0, 1,   1, 35, 1, 6, 0);   // two entries held
      add(1, 0, 0, 1,   1, 35, 2, 7, 0);
      add(1, 0, 1, 1,   0,  0, 0, 0, 0);   // clear beats the coincident match
      add(1, 0, 0, 1,   1,  0, 1, 1, 0);   // ts restarted at 0
      add(0, 1, 0, 1,   0,  0, 0, 1, 0);

      release_reset();
      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            step(vecs[i].sf, vecs[i].rdy, vecs[i].clr);
            check_state($sformatf("row%0d.%0d", i, r), vecs[i].ev, vecs[i].ts,
                        vecs[i].lvl, vecs[i].cnt, vecs[i].ovf);
         end
      end

      // Continuous matches with a ready consumer: count saturates at 255, no overflow
      step(0, 0, 1);
      for (int n = 1; n <= 300; n++) begin
         step(1, 1, 0);
         if (n == 254 || n == 255 || n == 256 || n == 300)
            check($sformatf("sat count after %0d", n), int'(match_count), (n < 255) ? n : 255);
      end
      check("sat overflow", int'(overflow), 0);
      check("sat fifo_level", int'(fifo_level), 1);
`ifndef SEQ_LOGGER_GAP_EN
      check("sat evt_ts", int'(evt_ts), last_ts);
`else
      check("sat evt_ts", int'(evt_ts), 0);
`endif

      // Matches at cycles 7, 8, 20 after reset release
`ifdef SEQ_LOGGER_GAP_EN
      exp_gap = '{7, 0, 11};
`else
      exp_gap = '{7, 8, 20};
`endif
      reset_n = 1'b0;
      step(0, 0, 0);
      check("mid reset fifo_level", int'(fifo_level), 0);
      release_reset();
      for (int c = 0; c <= 20; c++)
         step((c == 7 || c == 8 || c == 20), 1'b0, 1'b0);
      check("seq fifo_level", int'(fifo_level), 3);
      check("seq count", int'(match_count), 3);
      check("seq entry0", int'(evt_ts), exp_gap[0]);
      step(0, 1, 0);
      check("seq entry1", int'(evt_ts), exp_gap[1]);
      step(0, 1, 0);
      check("seq entry2", int'(evt_ts), exp_gap[2]);
      check("seq drain level", int'(fifo_level), 1);

      // Asynchronous reset mid-drain clears the FIFO without waiting for an edge
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset evt_valid", int'(evt_valid), 0);
      check("async reset fifo_level", int'(fifo_level), 0);
      check("async reset count", int'(match_count), 0);
      release_reset();
      step(0, 0, 0);
      check("post reset evt_valid", int'(evt_valid), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
